// File: rtl/rv_pkg.sv
// Shared RISC-V decode definitions: immediate-format codes, base opcodes and
// the ID-stage occupancy states.
package rv_pkg;

  localparam logic [2:0] ITYPE_R = 3'b000;
  localparam logic [2:0] ITYPE_I = 3'b001;
  localparam logic [2:0] ITYPE_B = 3'b010;
  localparam logic [2:0] ITYPE_S = 3'b011;
  localparam logic [2:0] ITYPE_U = 3'b100;
  localparam logic [2:0] ITYPE_J = 3'b101;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_e;

endpackage

// File: rtl/immdec.sv
// Immediate decoder: builds the sign- and zero-extended immediate for the
// given format from instruction bits [31:7]. R format yields zero.
module immdec
  import rv_pkg::*;
(
  input  logic [31:7] instr_hi,
  input  logic [2:0]  itype,
  output logic [31:0] simm,
  output logic [31:0] uimm
);

  logic [11:0] imm_i;
  logic [11:0] imm_s;
  logic [12:0] imm_b;
  logic [20:0] imm_j;

  assign imm_i = instr_hi[31:20];
  assign imm_s = {instr_hi[31:25], instr_hi[11:7]};
  assign imm_b = {instr_hi[31], instr_hi[7], instr_hi[30:25], instr_hi[11:8], 1'b0};
  assign imm_j = {instr_hi[31], instr_hi[19:12], instr_hi[20], instr_hi[30:21], 1'b0};

  always_comb begin
    simm = '0;
    uimm = '0;
    case (itype)
      ITYPE_I: begin
        simm = {{20{imm_i[11]}}, imm_i};
        uimm = {20'd0, imm_i};
      end
      ITYPE_S: begin
        simm = {{20{imm_s[11]}}, imm_s};
        uimm = {20'd0, imm_s};
      end
      ITYPE_B: begin
        simm = {{19{imm_b[12]}}, imm_b};
        uimm = {19'd0, imm_b};
      end
      ITYPE_U: begin
        simm = {instr_hi[31:12], 12'd0};
        uimm = {instr_hi[31:12], 12'd0};
      end
      ITYPE_J: begin
        simm = {{11{imm_j[20]}}, imm_j};
        uimm = {11'd0, imm_j};
      end
      default: begin
        simm = '0;
        uimm = '0;
      end
    endcase
  end

endmodule

// File: rtl/opc_classify.sv
// Maps a 7-bit RISC-V opcode onto its immediate-format code. Anything not in
// the supported base set (including words whose low two bits are not 11)
// decodes as R and is flagged illegal.
module opc_classify
  import rv_pkg::*;
(
  input  logic [6:0] opcode,
  output logic [2:0] itype,
  output logic       illegal
);

  always_comb begin
    itype   = ITYPE_R;
    illegal = 1'b0;
    case (opcode)
      OPC_LUI, OPC_AUIPC:  itype = ITYPE_U;
      OPC_JAL:             itype = ITYPE_J;
      OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_SYSTEM, OPC_MISC_MEM:
                           itype = ITYPE_I;
      OPC_BRANCH:          itype = ITYPE_B;
      OPC_STORE:           itype = ITYPE_S;
      OPC_OP:              itype = ITYPE_R;
      default:             illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/decode_stage_ctrl.sv
// ID-stage sequencer: valid/ready intake with a one-entry skid buffer so that
// if_ready is a flop, opcode/immediate decode, and the ID/EX register.
module decode_stage_ctrl
  import rv_pkg::*;
#(
  parameter int          XLEN         = 32,
  parameter logic [31:0] RESET_PC_TAG = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [XLEN-1:0] if_instr,
  input  logic [XLEN-1:0] if_pc,
  input  logic            flush,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_instr,
  output logic [2:0]      id_itype,
  output logic [XLEN-1:0] id_simm,
  output logic [XLEN-1:0] id_uimm,
  output logic [4:0]      id_rs1,
  output logic [4:0]      id_rs2,
  output logic [4:0]      id_rd,
  output logic            id_illegal
);

  state_e          state_q, state_d;
  logic            if_ready_q, if_ready_d;
  logic            id_valid_q, id_valid_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [2:0]      itype_q, itype_d;
  logic [XLEN-1:0] simm_q, simm_d;
  logic [XLEN-1:0] uimm_q, uimm_d;
  logic            illegal_q, illegal_d;
  logic [XLEN-1:0] skid_instr_q, skid_instr_d;
  logic [XLEN-1:0] skid_pc_q, skid_pc_d;

  logic [XLEN-1:0] sel_instr;
  logic [XLEN-1:0] sel_pc;
  logic [2:0]      dec_itype;
  logic            dec_illegal;
  logic [XLEN-1:0] dec_simm;
  logic [XLEN-1:0] dec_uimm;
  logic            xfer_in;
  logic            xfer_out;
  logic            load_main;
  logic            load_skid;

  // The skid entry is always older than the fetch input, so it decodes first.
  assign sel_instr = (state_q == SKID) ? skid_instr_q : if_instr;
  assign sel_pc    = (state_q == SKID) ? skid_pc_q    : if_pc;

  opc_classify u_opc_classify (
    .opcode  (sel_instr[6:0]),
    .itype   (dec_itype),
    .illegal (dec_illegal)
  );

  immdec u_immdec (
    .instr_hi (sel_instr[31:7]),
    .itype    (dec_itype),
    .simm     (dec_simm),
    .uimm     (dec_uimm)
  );

  assign xfer_in  = if_valid & if_ready_q;
  assign xfer_out = id_valid_q & id_ready;

  always_comb begin
    state_d      = state_q;
    load_main    = 1'b0;
    load_skid    = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (xfer_in) begin
          load_main = 1'b1;
          state_d   = FULL;
        end
        FULL: begin
          if (xfer_in && xfer_out) begin
            load_main = 1'b1;
          end else if (xfer_out) begin
            state_d = EMPTY;
          end else if (xfer_in) begin
            load_skid = 1'b1;
            state_d   = SKID;
          end
        end
        SKID: if (xfer_out) begin
          load_main = 1'b1;
          state_d   = FULL;
        end
        default: state_d = EMPTY;
      endcase
    end

    pc_d         = pc_q;
    instr_d      = instr_q;
    itype_d      = itype_q;
    simm_d       = simm_q;
    uimm_d       = uimm_q;
    illegal_d    = illegal_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    if (load_main) begin
      pc_d      = sel_pc;
      instr_d   = sel_instr;
      itype_d   = dec_itype;
      illegal_d = dec_illegal;
      // R format (legal or not) never carries an immediate.
      simm_d    = (dec_itype == ITYPE_R) ? '0 : dec_simm;
      uimm_d    = (dec_itype == ITYPE_R) ? '0 : dec_uimm;
    end
    if (load_skid) begin
      skid_instr_d = if_instr;
      skid_pc_d    = if_pc;
    end

    if_ready_d = (state_d != SKID);
    id_valid_d = (state_d != EMPTY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= EMPTY;
      if_ready_q   <= 1'b1;
      id_valid_q   <= 1'b0;
      pc_q         <= RESET_PC_TAG;
      instr_q      <= '0;
      itype_q      <= ITYPE_R;
      simm_q       <= '0;
      uimm_q       <= '0;
      illegal_q    <= 1'b0;
      skid_instr_q <= '0;
      skid_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      if_ready_q   <= if_ready_d;
      id_valid_q   <= id_valid_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      itype_q      <= itype_d;
      simm_q       <= simm_d;
      uimm_q       <= uimm_d;
      illegal_q    <= illegal_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  assign if_ready   = if_ready_q;
  assign id_valid   = id_valid_q;
  assign id_pc      = id_valid_q ? pc_q : RESET_PC_TAG;
  assign id_instr   = instr_q;
  assign id_itype   = itype_q;
  assign id_simm    = simm_q;
  assign id_uimm    = uimm_q;
  assign id_illegal = illegal_q;
  assign id_rs1     = instr_q[19:15];
  assign id_rs2     = instr_q[24:20];
  assign id_rd      = instr_q[11:7];

endmodule
